// File: rtl/timebase_if.sv
// Control inputs and pulse/index outputs of the timebase generator.
// Widths follow the seconds-per-minute and minutes-per-hour counts.
interface timebase_if #(
    parameter int SEC_PER_MIN  = 60,
    parameter int MIN_PER_HOUR = 60
);
    localparam int SW = $clog2(SEC_PER_MIN);
    localparam int MW = $clog2(MIN_PER_HOUR);

    logic          reset_count;
    logic          enable;
    logic          fastwatch;
    logic          one_sec;
    logic          one_min;
    logic          one_hour;
    logic [SW-1:0] sec_index;
    logic [MW-1:0] min_index;

    modport master (
        output reset_count, enable, fastwatch,
        input  one_sec, one_min, one_hour, sec_index, min_index
    );

    modport slave (
        input  reset_count, enable, fastwatch,
        output one_sec, one_min, one_hour, sec_index, min_index
    );
endinterface

// File: rtl/timebase_generator.sv
// Seconds/minutes/hours timebase derived from a clk prescaler, with a
// fastwatch mode where each second counts as a minute.
module timebase_generator #(
    parameter int TICKS_PER_SEC = 256,
    parameter int SEC_PER_MIN   = 60,
    parameter int MIN_PER_HOUR  = 60
) (
    input  logic       clk,
    input  logic       reset,
    timebase_if.slave  bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int SW = $clog2(SEC_PER_MIN);
    localparam int MW = $clog2(MIN_PER_HOUR);

    logic [PW-1:0] presc_reg, presc_next;
    logic [SW-1:0] sec_reg, sec_next;
    logic [MW-1:0] min_reg, min_next;
    logic          sec_pulse_reg, min_pulse_reg, hour_pulse_reg;
    logic          sec_event, min_event, hour_event;
    logic          sec_pulse_next, min_pulse_next, hour_pulse_next;

    assign sec_event  = bus.enable && (presc_reg == PW'(TICKS_PER_SEC - 1));
    assign min_event  = sec_event && (bus.fastwatch || (sec_reg == SW'(SEC_PER_MIN - 1)));
    assign hour_event = min_event && (min_reg == MW'(MIN_PER_HOUR - 1));

    always_comb begin
        presc_next      = presc_reg;
        sec_next        = sec_reg;
        min_next        = min_reg;
        sec_pulse_next  = sec_event;
        min_pulse_next  = min_event;
        hour_pulse_next = hour_event;

        if (bus.enable) begin
            presc_next = sec_event ? '0 : presc_reg + PW'(1);
        end

        // Fastwatch pins the second index to 0 even while paused.
        if (bus.fastwatch) begin
            sec_next = '0;
        end else if (sec_event) begin
            sec_next = (sec_reg == SW'(SEC_PER_MIN - 1)) ? '0 : sec_reg + SW'(1);
        end

        if (min_event) begin
            min_next = hour_event ? '0 : min_reg + MW'(1);
        end

        if (bus.reset_count) begin
            presc_next      = '0;
            sec_next        = '0;
            min_next        = '0;
            sec_pulse_next  = 1'b0;
            min_pulse_next  = 1'b0;
            hour_pulse_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg      <= '0;
            sec_reg        <= '0;
            min_reg        <= '0;
            sec_pulse_reg  <= 1'b0;
            min_pulse_reg  <= 1'b0;
            hour_pulse_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            sec_reg        <= sec_next;
            min_reg        <= min_next;
            sec_pulse_reg  <= sec_pulse_next;
            min_pulse_reg  <= min_pulse_next;
            hour_pulse_reg <= hour_pulse_next;
        end
    end

    assign bus.one_sec   = sec_pulse_reg;
    assign bus.one_min   = min_pulse_reg;
    assign bus.one_hour  = hour_pulse_reg;
    assign bus.sec_index = sec_reg;
    assign bus.min_index = min_reg;
endmodule

// File: tb/tb_timebase_generator.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and
// compares them every clk; directed phases add pulse-count checks.
module tb_timebase_generator;
    localparam int T = 4;
    localparam int S = 3;
    localparam int M = 2;

    typedef struct packed {
        logic       s;
        logic       m;
        logic       h;
        logic [1:0] si;
        logic       mi;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_d = 1'b1;
    always #5 clk = ~clk;

    timebase_if #(.SEC_PER_MIN(S), .MIN_PER_HOUR(M)) tb_bus ();
    timebase_if def_bus ();

    timebase_generator #(.TICKS_PER_SEC(T), .SEC_PER_MIN(S), .MIN_PER_HOUR(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_bus.slave)
    );

    timebase_generator dut_def (
        .clk   (clk),
        .reset (reset_d),
        .bus   (def_bus.slave)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    int   cnt_sec = 0, cnt_min = 0, cnt_hour = 0;
    int   m_ticks = 0, m_sec = 0, m_min = 0;
    logic last_min = 1'b0;

    // Monitor: one expectation per clk edge, compared 1 time unit later.
    exp_t mon_e;
    logic mon_bad;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            checks++;
            mon_bad = 1'b0;
            if (tb_bus.one_sec !== mon_e.s) begin
                $display("FAIL one_sec txn %0d: got %b want %b", txn, tb_bus.one_sec, mon_e.s);
                mon_bad = 1'b1;
            end
            if (tb_bus.one_min !== mon_e.m) begin
                $display("FAIL one_min txn %0d: got %b want %b", txn, tb_bus.one_min, mon_e.m);
                mon_bad = 1'b1;
            end
            if (tb_bus.one_hour !== mon_e.h) begin
                $display("FAIL one_hour txn %0d: got %b want %b", txn, tb_bus.one_hour, mon_e.h);
                mon_bad = 1'b1;
            end
            if (tb_bus.sec_index !== mon_e.si) begin
                $display("FAIL sec_index txn %0d: got %0d want %0d", txn, tb_bus.sec_index, mon_e.si);
                mon_bad = 1'b1;
            end
            if (tb_bus.min_index !== mon_e.mi) begin
                $display("FAIL min_index txn %0d: got %0d want %0d", txn, tb_bus.min_index, mon_e.mi);
                mon_bad = 1'b1;
            end
            if (mon_bad) errors++;
            cnt_sec  += int'(tb_bus.one_sec);
            cnt_min  += int'(tb_bus.one_min);
            cnt_hour += int'(tb_bus.one_hour);
            $display("txn %0d: sec=%b min=%b hour=%b sec_index=%0d min_index=%0d",
                     txn, tb_bus.one_sec, tb_bus.one_min, tb_bus.one_hour,
                     tb_bus.sec_index, tb_bus.min_index);
        end
    end

    // Reference: integer clock arithmetic straight from the timekeeping rules.
    task automatic model_step(input logic r, input logic rc, input logic en, input logic fw);
        exp_t e;
        logic minute;
        e = '0;
        minute = 1'b0;
        if (r || rc) begin
            m_ticks = 0;
            m_sec   = 0;
            m_min   = 0;
        end else begin
            if (fw) m_sec = 0;
            if (en) begin
                m_ticks = (m_ticks + 1) % T;
                if (m_ticks == 0) begin
                    e.s = 1'b1;
                    if (fw) begin
                        minute = 1'b1;
                    end else begin
                        m_sec  = (m_sec + 1) % S;
                        minute = (m_sec == 0);
                    end
                    if (minute) begin
                        e.m   = 1'b1;
                        m_min = (m_min + 1) % M;
                        e.h   = (m_min == 0);
                    end
                end
            end
        end
        e.si = 2'(m_sec);
        e.mi = 1'(m_min);
        last_min = e.m;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic rc, input logic en, input logic fw);
        @(negedge clk);
        reset                = r;
        tb_bus.reset_count   = rc;
        tb_bus.enable        = en;
        tb_bus.fastwatch     = fw;
        model_step(r, rc, en, fw);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    int s0, m0, h0;
    int d_sec, d_min, d_hour;
    logic fw_r;

    initial begin
        tb_bus.reset_count = 1'b0;
        tb_bus.enable      = 1'b0;
        tb_bus.fastwatch   = 1'b0;
        def_bus.reset_count = 1'b0;
        def_bus.enable      = 1'b1;
        def_bus.fastwatch   = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Normal run from reset release: 24 cycles.
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hour;
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run24_one_sec_count", cnt_sec - s0, 6);
        chk("run24_one_min_count", cnt_min - m0, 2);
        chk("run24_one_hour_count", cnt_hour - h0, 1);
        chk("run24_one_hour_last", int'(tb_bus.one_hour), 1);

        // Reach sec_index=2, then fastwatch.
        for (int i = 0; i < 20 && m_sec != 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_fw_sec_index", int'(tb_bus.sec_index), 2);
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hour;
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fw_clear_sec_index", int'(tb_bus.sec_index), 0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fw_one_sec_count", cnt_sec - s0, 4);
        chk("fw_one_min_count", cnt_min - m0, 4);
        chk("fw_one_hour_count", cnt_hour - h0, 2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Pause with prescaler at 2.
        for (int i = 0; i < 10 && m_ticks != 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hour;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_pulses", (cnt_sec - s0) + (cnt_min - m0) + (cnt_hour - h0), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_1_one_sec", cnt_sec - s0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_2_one_sec", cnt_sec - s0, 1);

        // reset_count on the cycle a second is due.
        for (int i = 0; i < 10 && m_ticks != 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        s0 = cnt_sec;
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rc_no_pulse", cnt_sec - s0, 0);
        chk("rc_sec_index", int'(tb_bus.sec_index), 0);
        chk("rc_min_index", int'(tb_bus.min_index), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rc_release_3_one_sec", cnt_sec - s0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rc_release_4_one_sec", cnt_sec - s0, 1);

        // Async reset between edges while one_min is high.
        for (int i = 0; i < 40 && !last_min; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("async_pre_one_min", int'(tb_bus.one_min), 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_one_min", int'(tb_bus.one_min), 0);
        chk("async_one_sec", int'(tb_bus.one_sec), 0);
        chk("async_sec_index", int'(tb_bus.sec_index), 0);
        chk("async_min_index", int'(tb_bus.min_index), 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        fw_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 5) fw_r = ~fw_r;
            cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 80, fw_r);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Default-parameter instance: one full minute.
        @(negedge clk);
        reset_d = 1'b0;
        d_sec = 0; d_min = 0; d_hour = 0;
        for (int i = 0; i < 15360; i++) begin
            @(posedge clk);
            #1;
            d_sec  += int'(def_bus.one_sec);
            d_min  += int'(def_bus.one_min);
            d_hour += int'(def_bus.one_hour);
        end
        chk("default_one_sec_count", d_sec, 60);
        chk("default_one_min_count", d_min, 1);
        chk("default_one_hour_count", d_hour, 0);
        chk("default_sec_index", int'(def_bus.sec_index), 0);
        chk("default_min_index", int'(def_bus.min_index), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timebase_generator.md
TIMEBASE_GENERATOR -- requirements
Module: timebase_generator

Interface
REQ-001 SHALL provide parameter TICKS_PER_SEC, default 256, clk cycles per second; legal range >= 2.
REQ-002 SHALL provide parameter SEC_PER_MIN, default 60, seconds per minute; legal range >= 2.
REQ-003 SHALL provide parameter MIN_PER_HOUR, default 60, minutes per hour; legal range >= 2.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port reset_count, input, 1, synchronous clear of all counters and pulses.
REQ-007 SHALL provide port enable, input, 1; when high, the timebase advances; when low, it pauses.
REQ-008 SHALL provide port fastwatch, input, 1; selects accelerated mode, one minute per second.
REQ-009 SHALL provide port one_sec, output, 1, one-cycle registered pulse per second.
REQ-010 SHALL provide port one_min, output, 1, one-cycle registered pulse per minute.
REQ-011 SHALL provide port one_hour, output, 1, one-cycle registered pulse per hour.
REQ-012 SHALL provide port sec_index, output, clog2(SEC_PER_MIN), the current second within the minute.
REQ-013 SHALL provide port min_index, output, clog2(MIN_PER_HOUR), the current minute within the hour.

Function
REQ-014 The prescaler SHALL count 0..TICKS_PER_SEC-1 on each enabled cycle and wrap to 0.
REQ-015 On a prescaler wrap edge, one_sec SHALL be high for exactly the following cycle; the period SHALL be exactly TICKS_PER_SEC enabled cycles.
REQ-016 In normal mode (fastwatch=0), sec_index SHALL increment on each prescaler wrap and wrap from SEC_PER_MIN-1 to 0.
REQ-017 In normal mode, one_min SHALL pulse on the same cycle as the one_sec pulse that follows the sec_index wrap.
REQ-018 min_index SHALL increment on each minute event and wrap from MIN_PER_HOUR-1 to 0.
REQ-019 one_hour SHALL pulse on the same cycle as the one_min pulse that follows the min_index wrap.
REQ-020 In fastwatch mode, each prescaler wrap SHALL be a minute event, so one_min equals one_sec cycle for cycle.
REQ-021 In fastwatch mode, sec_index SHALL be held at 0, and it SHALL be cleared on the first fastwatch cycle.
REQ-022 When fastwatch falls, sec_index SHALL resume from 0; the prescaler and min_index SHALL be unaffected by either fastwatch edge.
REQ-023 With enable=0, the prescaler, sec_index and min_index SHALL hold, and all three pulse outputs SHALL be 0 on the next cycle.
REQ-024 reset_count SHALL take priority over enable and fastwatch.
REQ-025 On the edge where reset_count=1, all counters and pulse outputs SHALL clear; the next prescaler wrap SHALL occur TICKS_PER_SEC enabled cycles after reset_count falls.
REQ-026 Pulse outputs SHALL never be high for more than one consecutive cycle.
REQ-027 Counter widths SHALL hold their maximum value without overflow for any legal parameter.

Reset
REQ-028 While reset=1, independent of clk, the prescaler, sec_index and min_index SHALL be 0, and one_sec, one_min and one_hour SHALL be 0.
REQ-029 A reset asserted mid-second SHALL discard the partial count; the first one_sec after release SHALL follow TICKS_PER_SEC enabled cycles.

Verification (bench parameters: TICKS_PER_SEC=4, SEC_PER_MIN=3, MIN_PER_HOUR=2)
REQ-030 Release reset with enable=1 and run 24 cycles -> one_sec is high in cycles 4, 8, ... 24; one_min is high in cycles 12 and 24; one_hour is high only in cycle 24; sec_index and min_index are 0 at cycle 24.
REQ-031 Set fastwatch=1 with sec_index=2 -> sec_index=0 next cycle; each one_sec coincides with one_min; one_hour pulses every 8 cycles.
REQ-032 Drop enable for 5 cycles when the prescaler=2 -> no pulses during the pause; the next one_sec occurs 2 enabled cycles after enable returns.
REQ-033 Assert reset_count with enable=1 on the cycle a one_sec is due -> no pulse; all counters are 0; the next one_sec occurs 4 cycles after release.
REQ-034 Assert async reset between clk edges while one_min=1 -> one_min and all indices drop immediately, without waiting for a clk edge.
REQ-035 Run default parameters for 15360 cycles -> exactly 60 one_sec pulses and exactly 1 one_min pulse.
